// File: rtl/dot_accel_if.sv
// Avalon-MM bus bundle for dot_accel.
// Used for both the CPU slave port and the SDRAM master port.
interface dot_accel_if #(
  parameter int AW = 32
) ();
  logic          waitrequest;
  logic [AW-1:0] address;
  logic          read;
  logic [31:0]   readdata;
  logic          readdatavalid;
  logic          write;
  logic [31:0]   writedata;

  modport master (
    input  waitrequest,
    input  readdata,
    input  readdatavalid,
    output address,
    output read,
    output write,
    output writedata
  );

  modport slave (
    output waitrequest,
    output readdata,
    input  address,
    input  read,
    input  write,
    input  writedata
  );
endinterface

// File: rtl/dot_accel.sv
// Q16.16 dot-product engine: streams two vectors over Avalon-MM, writes acc+bias.
// Define DOT_RELU_EN to clamp negative results to zero.
module dot_accel (
  input  logic       clk,
  input  logic       rst,
  dot_accel_if.slave  slave,
  dot_accel_if.master master
);

  typedef enum logic [2:0] {
    IDLE, RDW, WAITW, RDA, WAITA, MAC, FIN, WR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] bias_q, bias_d;
  logic [31:0] wbase_q, wbase_d;
  logic [31:0] abase_q, abase_d;
  logic [31:0] n_q, n_d;
  logic [31:0] oaddr_q, oaddr_d;
  logic [31:0] res_q, res_d;
  logic [31:0] wptr_q, wptr_d;
  logic [31:0] aptr_q, aptr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] w_q, w_d;
  logic [31:0] a_q, a_d;
  logic        mrd_q, mrd_d;
  logic        mwr_q, mwr_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;

  logic signed [63:0] prod64;
  logic [15:0] prod_unused_hi;
  logic [15:0] prod_unused_lo;
  logic [31:0] prod;
  logic [31:0] sum;
  logic [31:0] fin;
  logic [31:0] rdata;
  logic        idle;

  assign idle   = (state_q == IDLE);
  assign prod64 = $signed(w_q) * $signed(a_q);
  assign {prod_unused_hi, prod, prod_unused_lo} = prod64;
  assign sum    = acc_q + bias_q;

`ifdef DOT_RELU_EN
  assign fin = sum[31] ? 32'd0 : sum;
`else
  assign fin = sum;
`endif

  assign slave.waitrequest = !idle && (slave.read || slave.write);
  assign slave.readdata    = rdata;

  assign master.read      = mrd_q;
  assign master.write     = mwr_q;
  assign master.address   = maddr_q;
  assign master.writedata = mwdata_q;

  always_comb begin
    rdata = '0;
    case (slave.address[3:0])
      4'd0:    rdata = res_q;
      4'd1:    rdata = bias_q;
      4'd2:    rdata = wbase_q;
      4'd3:    rdata = abase_q;
      4'd4:    rdata = n_q;
      4'd5:    rdata = oaddr_q;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    bias_d   = bias_q;
    wbase_d  = wbase_q;
    abase_d  = abase_q;
    n_d      = n_q;
    oaddr_d  = oaddr_q;
    res_d    = res_q;
    wptr_d   = wptr_q;
    aptr_d   = aptr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    w_d      = w_q;
    a_d      = a_q;
    mrd_d    = mrd_q;
    mwr_d    = mwr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      IDLE: begin
        if (slave.write) begin
          unique case (1'b1)
            (slave.address[3:0] == 4'd0): begin
              wptr_d = wbase_q;
              aptr_d = abase_q;
              cnt_d  = n_q;
              acc_d  = '0;
              // Empty vector still goes through FIN so the bias lands
              if (n_q == '0) begin
                state_d = FIN;
              end else begin
                state_d = RDW;
                mrd_d   = 1'b1;
                maddr_d = wbase_q;
              end
            end
            (slave.address[3:0] == 4'd1): bias_d  = slave.writedata;
            (slave.address[3:0] == 4'd2): wbase_d = slave.writedata;
            (slave.address[3:0] == 4'd3): abase_d = slave.writedata;
            (slave.address[3:0] == 4'd4): n_d     = slave.writedata;
            (slave.address[3:0] == 4'd5): oaddr_d = slave.writedata;
            default: ;
          endcase
        end
      end
      RDW: begin
        if (!master.waitrequest) begin
          mrd_d   = 1'b0;
          state_d = WAITW;
        end
      end
      WAITW: begin
        if (master.readdatavalid) begin
          w_d     = master.readdata;
          mrd_d   = 1'b1;
          maddr_d = aptr_q;
          state_d = RDA;
        end
      end
      RDA: begin
        if (!master.waitrequest) begin
          mrd_d   = 1'b0;
          state_d = WAITA;
        end
      end
      WAITA: begin
        if (master.readdatavalid) begin
          a_d     = master.readdata;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d  = acc_q + prod;
        wptr_d = wptr_q + 32'd4;
        aptr_d = aptr_q + 32'd4;
        cnt_d  = cnt_q - 32'd1;
        if (cnt_q != 32'd1) begin
          mrd_d   = 1'b1;
          maddr_d = wptr_q + 32'd4;
          state_d = RDW;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        res_d    = fin;
        mwr_d    = 1'b1;
        maddr_d  = oaddr_q;
        mwdata_d = fin;
        state_d  = WR;
      end
      WR: begin
        if (!master.waitrequest) begin
          mwr_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bias_q   <= '0;
      wbase_q  <= '0;
      abase_q  <= '0;
      n_q      <= '0;
      oaddr_q  <= '0;
      res_q    <= '0;
      wptr_q   <= '0;
      aptr_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      w_q      <= '0;
      a_q      <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      bias_q   <= bias_d;
      wbase_q  <= wbase_d;
      abase_q  <= abase_d;
      n_q      <= n_d;
      oaddr_q  <= oaddr_d;
      res_q    <= res_d;
      wptr_q   <= wptr_d;
      aptr_q   <= aptr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      w_q      <= w_d;
      a_q      <= a_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

endmodule

// File: tb/tb_dot_accel.sv
// Directed bench for dot_accel with an SDRAM responder model.
// Expected results are hand-computed Q16.16 values.
module tb_dot_accel;

`ifdef DOT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  localparam logic [31:0] WB = 32'h100;
  localparam logic [31:0] AB = 32'h200;
  localparam logic [31:0] OA = 32'h300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_accel_if #(.AW(4))  s_if ();
  dot_accel_if #(.AW(32)) m_if ();

  dot_accel dut (
    .clk    (clk),
    .rst    (rst),
    .slave  (s_if.slave),
    .master (m_if.master)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] mem [0:1023];
  int          lat_cnt = -1;
  logic [31:0] pend;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  int          wr_edge = 0;
  int          viol = 0;
  bit          stall_en = 1'b0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  bit          p_req = 1'b0;
  bit          p_wr = 1'b0;
  logic        p_rd, p_w;
  logic [31:0] p_a, p_d;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] relu(input logic [31:0] x);
    return (RELU && x[31]) ? 32'd0 : x;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // SDRAM responder: decides waitrequest per cycle, returns read data late
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    m_if.waitrequest   = 1'b0;
    m_if.readdata      = '0;
    m_if.readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      m_if.readdatavalid = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          m_if.readdatavalid = 1'b1;
          m_if.readdata      = pend;
          lat_cnt            = -1;
        end
      end
      if (!rst && p_req && p_wr) begin
        if (m_if.read !== p_rd || m_if.write !== p_w ||
            m_if.address !== p_a || m_if.writedata !== p_d)
          viol++;
      end
      m_if.waitrequest = stall_en ? ($urandom_range(2, 0) == 0) : 1'b0;
      p_req = !rst && (m_if.read || m_if.write);
      p_wr  = m_if.waitrequest;
      p_rd  = m_if.read;
      p_w   = m_if.write;
      p_a   = m_if.address;
      p_d   = m_if.writedata;
      if (!rst && !m_if.waitrequest) begin
        if (m_if.read) begin
          rd_cnt++;
          pend    = mem[m_if.address[11:2]];
          lat_cnt = $urandom_range(lat_hi, lat_lo);
        end
        if (m_if.write) begin
          wr_cnt++;
          last_wa = m_if.address;
          last_wd = m_if.writedata;
          wr_edge = cyc + 1;
          mem[m_if.address[11:2]] = m_if.writedata;
        end
      end
    end
  end

  task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d,
                        output int edge_o, output bit stalled);
    int i;
    @(negedge clk);
    s_if.address   = a;
    s_if.writedata = d;
    s_if.write     = 1'b1;
    #1;
    stalled = s_if.waitrequest;
    i = 0;
    while (s_if.waitrequest && i < 3000) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (i >= 3000) chk("cpu_wr_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    edge_o     = cyc;
    s_if.write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [31:0] d);
    int i;
    @(negedge clk);
    s_if.address = a;
    s_if.read    = 1'b1;
    #1;
    i = 0;
    while (s_if.waitrequest && i < 3000) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (i >= 3000) chk("cpu_rd_timeout", 32'd1, 32'd0);
    d = s_if.readdata;
    @(posedge clk);
    #1;
    s_if.read = 1'b0;
  endtask

  task automatic prog(input logic [31:0] bias, input logic [31:0] n);
    int e;
    bit s;
    cpu_wr(4'd1, bias, e, s);
    cpu_wr(4'd2, WB, e, s);
    cpu_wr(4'd3, AB, e, s);
    cpu_wr(4'd4, n, e, s);
    cpu_wr(4'd5, OA, e, s);
  endtask

  task automatic wait_wr(input string tag, input int target);
    int i = 0;
    while (wr_cnt < target && i < 5000) begin
      @(posedge clk);
      i++;
    end
    chk(tag, 32'(wr_cnt >= target), 32'd1);
    @(negedge clk);
  endtask

  task automatic load_t1();
    mem[WB[11:2]]     = 32'h00010000;
    mem[WB[11:2] + 1] = 32'h00020000;
    mem[WB[11:2] + 2] = 32'hFFFF0000;
    mem[AB[11:2]]     = 32'h00008000;
    mem[AB[11:2] + 1] = 32'h00004000;
    mem[AB[11:2] + 2] = 32'h00030000;
  endtask

  initial begin
    int e, e2, rc, wc, i;
    bit st;
    logic [31:0] d;
    s_if.address       = '0;
    s_if.read          = 1'b0;
    s_if.write         = 1'b0;
    s_if.writedata     = '0;
    s_if.readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mread", 32'(m_if.read), 32'd0);
    chk("rst_mwrite", 32'(m_if.write), 32'd0);
    chk("rst_maddr", m_if.address, 32'd0);
    chk("rst_mwdata", m_if.writedata, 32'd0);
    chk("rst_swait", 32'(s_if.waitrequest), 32'd0);
    cpu_rd(4'd0, d);
    chk("rst_result", d, 32'd0);

    // n=3: 0.5 + 0.5 - 3.0 + 0.5 = -1.5
    load_t1();
    prog(32'h00008000, 32'd3);
    cpu_rd(4'd7, d);
    chk("word7_zero", d, 32'd0);
    rc = rd_cnt;
    wc = wr_cnt;
    cpu_wr(4'd0, 32'd0, e, st);
    wait_wr("t1_done", wc + 1);
    chk("t1_addr", last_wa, OA);
    chk("t1_data", last_wd, relu(32'hFFFE8000));
    chk("t1_cycles", 32'(wr_edge - e), 32'd17);
    chk("t1_reads", 32'(rd_cnt - rc), 32'd6);
    cpu_rd(4'd0, d);
    chk("t1_readback", d, relu(32'hFFFE8000));

    // n=0: result is just the bias
    prog(32'h00030000, 32'd0);
    rc = rd_cnt;
    wc = wr_cnt;
    cpu_wr(4'd0, 32'd0, e, st);
    cpu_rd(4'd0, d);
    chk("t2_readback", d, 32'h00030000);
    wait_wr("t2_done", wc + 1);
    chk("t2_addr", last_wa, OA);
    chk("t2_data", last_wd, 32'h00030000);
    chk("t2_cycles", 32'(wr_edge - e), 32'd2);
    chk("t2_reads", 32'(rd_cnt - rc), 32'd0);

    // truncation toward -inf: -2^-16 * 0.5 -> -2^-16
    mem[WB[11:2]] = 32'hFFFFFFFF;
    mem[AB[11:2]] = 32'h00008000;
    prog(32'd0, 32'd1);
    wc = wr_cnt;
    cpu_wr(4'd0, 32'd0, e, st);
    wait_wr("t3_done", wc + 1);
    chk("t3_trunc", last_wd, relu(32'hFFFFFFFF));

    // n=8 with stalls: w=1..8, a alternates 1.0/-0.5 -> 6.0, +bias
    for (int k = 0; k < 8; k++) begin
      mem[WB[11:2] + 10'(k)] = 32'(k + 1) << 16;
      mem[AB[11:2] + 10'(k)] = (k % 2 == 0) ? 32'h00010000 : 32'hFFFF8000;
    end
    prog(32'h00001000, 32'd8);
    stall_en = 1'b1;
    lat_lo   = 1;
    lat_hi   = 5;
    viol     = 0;
    rc = rd_cnt;
    wc = wr_cnt;
    cpu_wr(4'd0, 32'd0, e, st);
    wait_wr("t4_done", wc + 1);
    stall_en = 1'b0;
    lat_lo   = 1;
    lat_hi   = 1;
    repeat (2) @(negedge clk);
    chk("t4_data", last_wd, 32'h00061000);
    chk("t4_addr", last_wa, OA);
    chk("t4_reads", 32'(rd_cnt - rc), 32'd16);
    chk("t4_stable", 32'(viol), 32'd0);

    // overflow: (0x7FFF)^2 truncates to 1.0 each; bias wraps sign
    mem[WB[11:2]]     = 32'h7FFF0000;
    mem[WB[11:2] + 1] = 32'h7FFF0000;
    mem[AB[11:2]]     = 32'h7FFF0000;
    mem[AB[11:2] + 1] = 32'h7FFF0000;
    prog(32'h7FFF0000, 32'd2);
    wc = wr_cnt;
    cpu_wr(4'd0, 32'd0, e, st);
    wait_wr("t5_done", wc + 1);
    chk("t5_wrap", last_wd, relu(32'h80010000));

    // bias write during a run stalls and only affects the next run
    load_t1();
    prog(32'h00008000, 32'd3);
    wc = wr_cnt;
    cpu_wr(4'd0, 32'd0, e, st);
    cpu_wr(4'd1, 32'h00010000, e2, st);
    chk("t6_stalled", 32'(st), 32'd1);
    chk("t6_accept", 32'(e2 - e), 32'd18);
    wait_wr("t6_done", wc + 1);
    chk("t6_old_bias", last_wd, relu(32'hFFFE8000));
    wc = wr_cnt;
    cpu_wr(4'd0, 32'd0, e, st);
    wait_wr("t6b_done", wc + 1);
    chk("t6_new_bias", last_wd, relu(32'hFFFF0000));

    // reset during WAITA with a late read response in flight
    lat_lo = 5;
    lat_hi = 5;
    prog(32'h00008000, 32'd3);
    rc = rd_cnt;
    cpu_wr(4'd0, 32'd0, e, st);
    i = 0;
    while (rd_cnt < rc + 2 && i < 200) begin
      @(negedge clk);
      #2;
      i++;
    end
    chk("t7_reach", 32'(rd_cnt >= rc + 2), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #2;
    s_if.address = 4'd0;
    s_if.read    = 1'b1;
    rst          = 1'b1;
    #1;
    chk("t7_mread", 32'(m_if.read), 32'd0);
    chk("t7_mwrite", 32'(m_if.write), 32'd0);
    chk("t7_maddr", m_if.address, 32'd0);
    chk("t7_mwdata", m_if.writedata, 32'd0);
    chk("t7_swait", 32'(s_if.waitrequest), 32'd0);
    chk("t7_result", s_if.readdata, 32'd0);
    s_if.read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    rc = rd_cnt;
    wc = wr_cnt;
    repeat (10) @(negedge clk);
    chk("t7_no_reads", 32'(rd_cnt - rc), 32'd0);
    chk("t7_no_writes", 32'(wr_cnt - wc), 32'd0);
    lat_lo = 1;
    lat_hi = 1;
    prog(32'h00008000, 32'd3);
    cpu_wr(4'd0, 32'd0, e, st);
    wait_wr("t7_done", wc + 1);
    chk("t7_fresh", last_wd, relu(32'hFFFE8000));
    chk("t7_cycles", 32'(wr_edge - e), 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
